seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's common-anode 8-digit seven-segment display.
- Drives one shared hex-to-segment decoder: presents one digit's nibble, decimal point and blank (LE) per time slot, and asserts the matching active-low anode.
- Holds a shadow copy of the display contents, updated only at frame boundaries via a req/ack handshake, so digits never tear.
- Inserts an all-anodes-off guard gap between digits to prevent ghosting; supports optional leading-zero suppression.

Parameters:
DIGITS, 8, number of digits scanned (1..8)
SCAN_DIV, 100000, clock cycles per digit slot (1 kHz/digit at 100 MHz); must be > GAP_CYC
GAP_CYC, 2000, cycles at start of each slot with all anodes off and LE=1; 0 disables the gap

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
data_in  input  4*DIGITS  hex nibbles; digit k = data_in[4k+3:4k], digit 0 rightmost
point_in  input  DIGITS  decimal point request per digit, 1 = lit
blank_in  input  DIGITS  per-digit blank, 1 = dark
lz_en  input  1  leading-zero suppression enable (sampled with shadow update)
upd_req  input  1  level request to copy data_in/point_in/blank_in/lz_en into shadow; hold until upd_ack
upd_ack  output  1  one-cycle pulse: shadow copied this cycle
hex  output  4  nibble to decoder D3..D0
point  output  1  to decoder point input (1 = dp lit; decoder inverts)
le  output  1  to decoder LE, 1 = all segments off
an  output  DIGITS  anode select, active-low one-hot, all-ones = off
frame_tick  output  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (async, rst_n=0): cnt=0, idx=0, an=all ones, le=1, hex=0, point=0, upd_ack=0, frame_tick=0; shadow data=0, point=0, blank=all ones, lz=0. Display stays dark until the first update.
- All outputs are registered, with no combinational path from inputs to outputs.
- Slot counter cnt runs 0..SCAN_DIV-1, then wraps and advances idx; idx wraps DIGITS-1 -> 0.
- Gap phase (cnt < GAP_CYC): an=all ones, le=1; hex/point already show digit idx.
- Show phase (cnt >= GAP_CYC): an bit idx = 0, others 1; hex = shadow nibble idx; point = shadow point[idx]; le = shadow blank[idx] OR suppressed(idx).
- suppressed(k) = lz AND k>0 AND all shadow nibbles k..DIGITS-1 equal 0. Digit 0 is never suppressed. Blanked or suppressed digits still get their slot time, so brightness is uniform.
- After reset release, sequence is: GAP_CYC cycles an=all ones, then SCAN_DIV-GAP_CYC cycles with an[0]=0, then the same for digit 1, and so on.
- Frame boundary = the cycle cnt wraps with idx=DIGITS-1; in the next cycle idx=0 and cnt=0.
  - frame_tick pulses in that first cycle of the new frame.
  - If upd_req=1 at the boundary: shadow <= inputs, and upd_ack pulses in the same cycle as frame_tick. New contents apply from digit 0 of that frame onward.
  - upd_req dropped before the boundary: no update, no ack.
  - upd_req still high after ack: another update at the next boundary.
  - No mid-frame shadow change under any input activity.
- The first frame_tick occurs SCAN_DIV*DIGITS cycles after reset release. Reset does not generate a tick.
- GAP_CYC=0: no gap; an switches directly between neighbouring digits.
- Reset asserted mid-slot: outputs go to reset values immediately, and the pending update is discarded.

Test Plan:
- Reset/dark: DIGITS=4, SCAN_DIV=8, GAP_CYC=2, no upd_req -> an cycles 1111x2, 1110x6, 1111x2, 1101x6, ...; le=1 throughout; frame_tick every 32 cycles.
- Update handshake: raise upd_req with data_in=16'h1A3F, point_in=4'b0100, blank_in=0 -> upd_ack coincides with next frame_tick. Show slots then give hex F,3,A,1 with point=1 only on digit 2, le=0 in show and 1 in gap.
- Request timing: pulse upd_req 3 cycles then drop before the boundary -> no upd_ack, shadow unchanged. Hold upd_req across 2 boundaries -> two upd_ack pulses 32 cycles apart.
- Leading-zero suppression: data 16'h0050, lz_en=1 -> le=1 on digits 3 and 2, le=0 on digits 1 and 0. With data 16'h0000 -> only digit 0 lit, showing 0. With lz_en=0 -> all digits lit.
- Blank mask and no gap: GAP_CYC=0, blank_in=4'b1010 -> an switches with no all-ones cycles; le=1 exactly on digits 1 and 3.
- Async reset mid-frame: assert rst_n=0 during digit 2 show -> same cycle an=1111, le=1, shadow cleared. After release, scan restarts at digit 0 and the display stays dark until a new update.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - display contents, update handshake and decoder/anode drive bundle
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   point_in;
  logic [DIGITS-1:0]   blank_in;
  logic                lz_en;
  logic                upd_req;
  logic                upd_ack;
  logic [3:0]          hex;
  logic                point;
  logic                le;
  logic [DIGITS-1:0]   an;
  logic                frame_tick;

  modport master (
    output data_in, point_in, blank_in, lz_en, upd_req,
    input  upd_ack, hex, point, le, an, frame_tick
  );

  modport slave (
    input  data_in, point_in, blank_in, lz_en, upd_req,
    output upd_ack, hex, point, le, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan with frame-synchronous shadow update
module seg_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int GAP_CYC  = 2000
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_point_q, sh_point_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic                sh_lz_q, sh_lz_d;
  logic [3:0]          hex_q, hex_d;
  logic                point_q, point_d;
  logic                le_q, le_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                ack_q, ack_d;
  logic                tick_q, tick_d;

  logic                boundary;
  logic                gap;
  logic                all_zero;
  logic [DIGITS-1:0]   supp;

  always_comb begin
    boundary   = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    sh_data_d  = sh_data_q;
    sh_point_d = sh_point_q;
    sh_blank_d = sh_blank_q;
    sh_lz_d    = sh_lz_q;
    ack_d      = 1'b0;
    tick_d     = boundary;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Shadow only ever changes on the frame wrap, so a frame never mixes old and new digits
    if (boundary && bus.upd_req) begin
      sh_data_d  = bus.data_in;
      sh_point_d = bus.point_in;
      sh_blank_d = bus.blank_in;
      sh_lz_d    = bus.lz_en;
      ack_d      = 1'b1;
    end

    // Walk from the most significant digit down; a digit is suppressed while everything above is zero
    supp     = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (sh_data_d[4*k +: 4] == 4'h0);
      supp[k]  = sh_lz_d && (k != 0) && all_zero;
    end

    // Outputs are registered from next-state so they line up with cnt/idx of the same cycle
    gap     = (GAP_CYC != 0) && (int'(cnt_d) < GAP_CYC);
    hex_d   = sh_data_d[{idx_d, 2'b00} +: 4];
    point_d = sh_point_d[idx_d];
    an_d    = '1;
    le_d    = 1'b1;
    if (!gap) begin
      an_d[idx_d] = 1'b0;
      le_d        = sh_blank_d[idx_d] | supp[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_data_q  <= '0;
      sh_point_q <= '0;
      sh_blank_q <= '1;
      sh_lz_q    <= 1'b0;
      hex_q      <= 4'h0;
      point_q    <= 1'b0;
      le_q       <= 1'b1;
      an_q       <= '1;
      ack_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_data_q  <= sh_data_d;
      sh_point_q <= sh_point_d;
      sh_blank_q <= sh_blank_d;
      sh_lz_q    <= sh_lz_d;
      hex_q      <= hex_d;
      point_q    <= point_d;
      le_q       <= le_d;
      an_q       <= an_d;
      ack_q      <= ack_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.hex        = hex_q;
  assign bus.point      = point_q;
  assign bus.le         = le_q;
  assign bus.an         = an_q;
  assign bus.upd_ack    = ack_q;
  assign bus.frame_tick = tick_q;
endmodule
